// File: rtl/mdu_iterative.sv
// mdu_iterative
// ---------------------------------------------------------------------------
// Multi-cycle multiply/divide unit for the EX stage. It holds the next HI/LO
// values that feed the HI/LO register write inputs continuously.
//
// MULT/MULTU use a shift-add multiply and DIV/DIVU use a restoring divide.
// Each computes one bit per cycle for WIDTH cycles. One FIX cycle then
// applies sign correction and commits the result to HI/LO.
// MTHI/MTLO write hi_out/lo_out directly in one cycle and never assert busy.
//
// Optional feature (macro MDU_FAST_MUL_EN):
//   When defined, MULT/MULTU form the full product combinationally in the
//   accept cycle and go straight to FIX (IDLE->FIX->DONE).
//   Divide latency is unchanged.
//
// Ports:
//   clk    : pipeline clock, rising-edge state updates
//   rst    : asynchronous active-low reset
//   start  : request valid (one cycle)
//   op     : 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   flush  : abort an in-flight operation; drops a same-cycle start
//   a, b   : rs / rt operands
//   busy   : high while a mult/div is in progress
//   done   : one-cycle pulse when a mult/div result is committed
//   hi_out : current HI value
//   lo_out : current LO value
// ---------------------------------------------------------------------------
module mdu_iterative #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's complement negation, WIDTH bits
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    neg_w = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negation, 2*WIDTH bits
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    neg_2w = ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r;
  state_t             state_next_s;
  logic               accept_s;
  logic               mthi_s;
  logic               mtlo_s;
  logic               step_s;
  logic               commit_s;

  logic [CNT_W-1:0]   cnt_r;
  // Shared working register.
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend/quotient shift}.
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH-1:0]   opb_r;     // |b|: multiplicand or divisor
  logic [WIDTH-1:0]   raw_a_r;   // original a, returned as HI on divide by zero
  logic               is_div_r;
  logic               sign_a_r;
  logic               sign_b_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;

  logic               op_signed_s;
  logic [WIDTH-1:0]   abs_a_s;
  logic [WIDTH-1:0]   abs_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] mul_next_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH:0]     div_diff_s;
  logic               qbit_s;
  logic [2*WIDTH-1:0] div_next_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   hi_fix_s;
  logic [WIDTH-1:0]   lo_fix_s;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod_s;
`endif

  // Operand conditioning: MULT and DIV work on magnitudes
  always_comb begin
    op_signed_s = ~op[0];
    if (op_signed_s && a[WIDTH-1]) begin
      abs_a_s = neg_w(a);
    end else begin
      abs_a_s = a;
    end
    if (op_signed_s && b[WIDTH-1]) begin
      abs_b_s = neg_w(b);
    end else begin
      abs_b_s = b;
    end
  end

`ifdef MDU_FAST_MUL_EN
  // Single-cycle full product for the fast multiply path
  always_comb begin
    fast_prod_s = {{WIDTH{1'b0}}, abs_a_s} * {{WIDTH{1'b0}}, abs_b_s};
  end
`endif

  // One multiply iteration: conditional add of |b|, then shift right
  always_comb begin
    if (prod_r[0]) begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
    end else begin
      mul_sum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
    mul_next_s = {mul_sum_s, prod_r[WIDTH-1:1]};
  end

  // One restoring-divide iteration: shift in the next dividend bit, trial subtract
  always_comb begin
    rem_shift_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
    div_diff_s  = rem_shift_s - {1'b0, opb_r};
    // No borrow means the trial subtraction fits and the quotient bit is 1
    qbit_s      = ~div_diff_s[WIDTH];
    if (qbit_s) begin
      div_next_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], qbit_s};
    end else begin
      div_next_s = {rem_shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], qbit_s};
    end
  end

  // Sign correction and HI/LO selection for the commit edge
  always_comb begin
    prod_fix_s = prod_r;
    hi_fix_s   = prod_r[2*WIDTH-1:WIDTH];
    lo_fix_s   = prod_r[WIDTH-1:0];
    if (is_div_r) begin
      if (opb_r == {WIDTH{1'b0}}) begin
        // Divide by zero: raw dividend in HI, all ones in LO, no sign fix
        hi_fix_s = raw_a_r;
        lo_fix_s = {WIDTH{1'b1}};
      end else begin
        // The remainder takes the dividend's sign; the quotient is negative when the signs differ
        if (sign_a_r) begin
          hi_fix_s = neg_w(prod_r[2*WIDTH-1:WIDTH]);
        end else begin
          hi_fix_s = prod_r[2*WIDTH-1:WIDTH];
        end
        if (sign_a_r ^ sign_b_r) begin
          lo_fix_s = neg_w(prod_r[WIDTH-1:0]);
        end else begin
          lo_fix_s = prod_r[WIDTH-1:0];
        end
      end
    end else begin
      if (sign_a_r ^ sign_b_r) begin
        prod_fix_s = neg_2w(prod_r);
      end else begin
        prod_fix_s = prod_r;
      end
      hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // FSM next-state and per-cycle control strobes
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    mthi_s       = 1'b0;
    mtlo_s       = 1'b0;
    step_s       = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        state_next_s = ST_IDLE;
        // flush takes priority and drops a start in the same cycle
        if (start && !flush) begin
          case (op)
            OP_MTHI: mthi_s = 1'b1;
            OP_MTLO: mtlo_s = 1'b1;
            OP_MULT, OP_MULTU: begin
              accept_s = 1'b1;
`ifdef MDU_FAST_MUL_EN
              state_next_s = ST_FIX;
`else
              state_next_s = ST_CALC;
`endif
            end
            OP_DIV, OP_DIVU: begin
              accept_s     = 1'b1;
              state_next_s = ST_CALC;
            end
            default: state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_next_s = ST_FIX;
          end else begin
            state_next_s = ST_CALC;
          end
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_next_s = ST_IDLE;
        end else begin
          commit_s     = 1'b1;
          state_next_s = ST_DONE;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: operand latch, iteration, and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      opb_r    <= {WIDTH{1'b0}};
      raw_a_r  <= {WIDTH{1'b0}};
      is_div_r <= 1'b0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        cnt_r    <= {CNT_W{1'b0}};
        opb_r    <= abs_b_s;
        raw_a_r  <= a;
        is_div_r <= op[1];
        sign_a_r <= op_signed_s & a[WIDTH-1];
        sign_b_r <= op_signed_s & b[WIDTH-1];
`ifdef MDU_FAST_MUL_EN
        if (op[1]) begin
          prod_r <= {{WIDTH{1'b0}}, abs_a_s};
        end else begin
          prod_r <= fast_prod_s;
        end
`else
        prod_r   <= {{WIDTH{1'b0}}, abs_a_s};
`endif
      end else if (step_s) begin
        cnt_r <= cnt_r + CNT_ONE;
        if (is_div_r) begin
          prod_r <= div_next_s;
        end else begin
          prod_r <= mul_next_s;
        end
      end else begin
        cnt_r  <= cnt_r;
        prod_r <= prod_r;
      end
      busy_r <= (state_next_s == ST_CALC) || (state_next_s == ST_FIX);
      done_r <= (state_next_s == ST_DONE);
    end
  end

  // HI/LO holding registers: change only on commit or MTHI/MTLO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (commit_s) begin
      hi_r <= hi_fix_s;
      lo_r <= lo_fix_s;
    end else if (mthi_s) begin
      hi_r <= a;
    end else if (mtlo_s) begin
      lo_r <= a;
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign hi_out = hi_r;
  assign lo_out = lo_r;

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32).
// Table vectors with hand-derived results, randomized ops against a
// plain-arithmetic reference model, and hand sequences for reset, flush,
// ignored starts and MTHI/MTLO.
module tb_mdu_iterative;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic         flush;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] cur_hi = 32'h0;
  logic [W-1:0] cur_lo = 32'h0;

  mdu_iterative #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: architectural MIPS mult/div results from plain 64-bit arithmetic
  task automatic ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint sx, sy, p, q, r;
    longint unsigned up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    hi = 32'h0;
    lo = 32'h0;
    case (o)
      3'd0: begin p = sx * sy; hi = p[63:32]; lo = p[31:0]; end
      3'd1: begin up = {32'h0, x} * {32'h0, y}; hi = up[63:32]; lo = up[31:0]; end
      3'd2: begin
        if (y == 32'h0) begin hi = x; lo = 32'hFFFFFFFF; end
        else begin q = sx / sy; r = sx % sy; hi = r[31:0]; lo = q[31:0]; end
      end
      3'd3: begin
        if (y == 32'h0) begin hi = x; lo = 32'hFFFFFFFF; end
        else begin hi = x % y; lo = x / y; end
      end
      default: begin hi = 32'h0; lo = 32'h0; end
    endcase
  endtask

  // Issue one mult/div at a negedge and follow it to its done pulse
  task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int cyc;
    int bcnt;
    int exp_lat;
    exp_lat = (FAST && !o[1]) ? 2 : W + 2;
    start = 1'b1; op = o; a = ia; b = ib;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
    chk({nm, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({nm, " busy_cycles"}, 64'(bcnt), 64'(exp_lat - 1));
    chk({nm, " busy_at_done"}, 64'(busy), 64'h0);
    chk({nm, " hi"}, 64'(hi_out), 64'(eh));
    chk({nm, " lo"}, 64'(lo_out), 64'(el));
    cur_hi = eh;
    cur_lo = el;
  endtask

  // MTHI/MTLO: one edge, no busy, no done
  task automatic mt(input logic to_hi, input logic [31:0] d, input string nm);
    start = 1'b1; op = to_hi ? 3'b100 : 3'b101; a = d; b = 32'h0;
    @(negedge clk);
    start = 1'b0;
    if (to_hi) cur_hi = d; else cur_lo = d;
    chk({nm, " hi"}, 64'(hi_out), 64'(cur_hi));
    chk({nm, " lo"}, 64'(lo_out), 64'(cur_lo));
    chk({nm, " busy"}, 64'(busy), 64'h0);
    chk({nm, " done"}, 64'(done), 64'h0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, eh, el;
    int done_seen;

    tbl[0] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    tbl[1] = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    tbl[2] = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tbl[3] = '{3'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
    tbl[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    tbl[5] = '{3'd1, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
    tbl[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    tbl[7] = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    tbl[8] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    tbl[9] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

    rst = 1'b0; start = 1'b0; op = 3'b000; flush = 1'b0; a = 32'h0; b = 32'h0;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset hi", 64'(hi_out), 64'h0);
    chk("reset lo", 64'(lo_out), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Table vectors, issued back to back so each start lands in the DONE cycle
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));
    end

    // done is a single-cycle pulse
    @(negedge clk);
    chk("done pulse width", 64'(done), 64'h0);

    // Randomized ops against the reference model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        mt($urandom_range(0, 1) == 1, $urandom, $sformatf("rnd_mt%0d", i));
      end else begin
        ro = 3'($urandom_range(0, 3));
        ra = $urandom;
        rb = $urandom;
        if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 5));
        ref_model(ro, ra, rb, eh, el);
        run_op(ro, ra, rb, eh, el, $sformatf("rnd%0d_op%0d", i, ro));
      end
    end

    // Unused op code: no effect
    start = 1'b1; op = 3'b110; a = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    chk("unused op busy", 64'(busy), 64'h0);
    chk("unused op hi", 64'(hi_out), 64'(cur_hi));
    chk("unused op lo", 64'(lo_out), 64'(cur_lo));

    // flush in IDLE drops a same-cycle start
    start = 1'b1; flush = 1'b1; op = 3'b101; a = 32'h00000055;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle flush drops start lo", 64'(lo_out), 64'(cur_lo));
    chk("idle flush drops start busy", 64'(busy), 64'h0);

    // In-flight op, ignored MTHI at cycle 5, flush at cycle 10
    start = 1'b1; op = FAST ? 3'b011 : 3'b001; a = 32'h00012345; b = 32'h00000678;
    @(negedge clk);
    start = 1'b0;
    done_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done === 1'b1) done_seen++;
      if (c == 10) chk("flush busy before", 64'(busy), 64'h1);
      if (c == 11) chk("flush busy after", 64'(busy), 64'h0);
      start = (c == 5);
      op    = 3'b100;
      a     = 32'hDEADBEEF;
      flush = (c == 10);
      @(negedge clk);
    end
    start = 1'b0; flush = 1'b0;
    chk("flush no done", 64'(done_seen), 64'h0);
    chk("flush hi kept", 64'(hi_out), 64'(cur_hi));
    chk("flush lo kept", 64'(lo_out), 64'(cur_lo));

    // Unit still healthy after the flush
    run_op(tbl[9].op, tbl[9].a, tbl[9].b, tbl[9].hi, tbl[9].lo, "post_flush");

    // Asynchronous reset in the middle of a DIVU
    @(negedge clk);
    start = 1'b1; op = 3'b011; a = 32'h00000064; b = 32'h00000007;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid reset busy", 64'(busy), 64'h0);
    chk("mid reset done", 64'(done), 64'h0);
    chk("mid reset hi", 64'(hi_out), 64'h0);
    chk("mid reset lo", 64'(lo_out), 64'h0);
    cur_hi = 32'h0;
    cur_lo = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mt(1'b0, 32'h00001234, "post reset mtlo");
    repeat (40) @(negedge clk);
    chk("post reset idle busy", 64'(busy), 64'h0);
    chk("post reset lo stable", 64'(lo_out), 64'h00001234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
